// File: rtl/spi_regfile_peripheral.sv
// ============================================================================
// Module   : spi_regfile_peripheral
// Purpose  : SPI (mode 0) slave exposing a bank of NUM_REGS writable
//            registers of DATA_W bits. Frames are 8 command bits
//            (R/W, 7-bit address) followed by DATA_W data bits, MSB first.
//            Optional readback path enabled by macro SPI_READBACK_EN.
// Ports    : clock      - system clock, sole clock domain
//            rst        - synchronous active-high reset
//            sclk_in    - SPI clock (async)
//            ncs_in     - SPI chip select, active-low (async)
//            copi_in    - SPI controller-out data (async)
//            cipo_out   - SPI controller-in data
//            regs_out   - register file, reg n at [n*DATA_W +: DATA_W]
//            wr_pulse   - one-cycle strobe on write commit
//            wr_addr    - address of last committed write
//            frame_err  - one-cycle strobe when a frame is discarded
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_regfile_peripheral #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         sclk_in,
    input  logic                         ncs_in,
    input  logic                         copi_in,
    output logic                         cipo_out,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_pulse,
    output logic [6:0]                   wr_addr,
    output logic                         frame_err
);

    localparam int              FRAME_W  = 8 + DATA_W;
    localparam int              CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(7);
    localparam logic [7:0]       NREG_8   = 8'(NUM_REGS);

    // Synchronizers
    logic       sclk_s1, sclk_s2, sclk_s3;
    logic       ncs_s1, ncs_s2, ncs_s3;
    logic       copi_s1, copi_s2;
    // sync_vld marks when s2 holds a genuinely sampled pin value rather than
    // its reset value, so the armed flag is set only by a real ncs-high.
    logic [1:0] sync_vld;
    logic       armed;

    always_ff @(posedge clock) begin
        if (rst) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            ncs_s1   <= 1'b1;
            ncs_s2   <= 1'b1;
            ncs_s3   <= 1'b1;
            copi_s1  <= 1'b0;
            copi_s2  <= 1'b0;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sclk_s1  <= sclk_in;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            ncs_s1   <= ncs_in;
            ncs_s2   <= ncs_s1;
            ncs_s3   <= ncs_s2;
            copi_s1  <= copi_in;
            copi_s2  <= copi_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && ncs_s2) begin
                armed <= 1'b1;
            end
        end
    end

    logic sclk_rise, sclk_fall, ncs_rise, in_frame;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign ncs_rise  = ncs_s2 & ~ncs_s3;
    // Edges only count while selected; ncs high (incl. its rise) masks them.
    assign in_frame  = armed & ~ncs_s2;

    // Frame capture and register file
    logic [FRAME_W-1:0]         shift;
    logic [CNT_W-1:0]           cnt;
    logic [NUM_REGS*DATA_W-1:0] regs;

    logic              rw_bit;
    logic [6:0]        addr_fld;
    logic [DATA_W-1:0] data_fld;
    logic              addr_ok;
    assign rw_bit   = shift[FRAME_W-1];
    assign addr_fld = shift[FRAME_W-2 -: 7];
    assign data_fld = shift[DATA_W-1:0];
    assign addr_ok  = ({1'b0, addr_fld} < NREG_8);

    always_ff @(posedge clock) begin
        if (rst) begin
            shift     <= '0;
            cnt       <= '0;
            regs      <= '0;
            wr_pulse  <= 1'b0;
            wr_addr   <= 7'd0;
            frame_err <= 1'b0;
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            if (ncs_rise) begin
                if (cnt == CNT_FULL) begin
                    // Out-of-range writes and full-length reads are silent.
                    if (rw_bit && addr_ok) begin
                        regs[int'(addr_fld)*DATA_W +: DATA_W] <= data_fld;
                        wr_pulse <= 1'b1;
                        wr_addr  <= addr_fld;
                    end
                end else if (cnt != '0) begin
                    frame_err <= 1'b1;
                end
                shift <= '0;
                cnt   <= '0;
            end else if (in_frame && sclk_rise) begin
                shift <= {shift[FRAME_W-2:0], copi_s2};
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign regs_out = regs;

`ifdef SPI_READBACK_EN
    // Readback: load on the rise completing the 8th bit, shift out on falls.
    logic [DATA_W-1:0] out_shift;
    logic [DATA_W-1:0] rd_word;
    logic [6:0]        rd_addr;
    logic              cipo_r;

    // Address as it will be once the current copi bit is shifted in.
    assign rd_addr = {shift[5:0], copi_s2};

    always_comb begin
        rd_word = '0;
        if ({1'b0, rd_addr} < NREG_8) begin
            rd_word = regs[int'(rd_addr)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            out_shift <= '0;
            cipo_r    <= 1'b0;
        end else if (!in_frame) begin
            out_shift <= '0;
            cipo_r    <= 1'b0;
        end else if (sclk_rise && cnt == CNT_CMD && !shift[6]) begin
            out_shift <= rd_word;
        end else if (sclk_fall && cnt > CNT_CMD) begin
            cipo_r    <= out_shift[DATA_W-1];
            out_shift <= {out_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo_out = cipo_r;
`else
    assign cipo_out = 1'b0;
`endif

endmodule

`default_nettype wire
